// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with optional registered outputs
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    assign c[0] = CI;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum_d[i] = A[i] ^ B[i] ^ c[i];
        assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign carry_d = c[WIDTH];

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        // Capture the ripple result each edge; reset clears it immediately
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end
        assign Sum   = sum_q;
        assign Carry = carry_q;
    end else begin : g_comb
        assign Sum   = sum_d;
        assign Carry = carry_d;
    end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of full_adder in four configurations
module tb_full_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk0 = 1'b0;
    logic rst0 = 1'b0;
    int checks = 0;
    int errors = 0;

    logic        a1, b1, ci1, s1, c1;
    logic        a0, b0, ci0, s0, c0;
    logic [7:0]  a8, b8, s8;
    logic        ci8, c8;
    logic [15:0] a16, b16, s16;
    logic        ci16, c16;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .REG_OUT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .Sum(s1), .Carry(c1), .A(a1), .B(b1), .CI(ci1));
    full_adder #(.WIDTH(1), .REG_OUT(0)) u_comb (
        .clk(clk0), .rst_n(rst0), .Sum(s0), .Carry(c0), .A(a0), .B(b0), .CI(ci0));
    full_adder #(.WIDTH(8), .REG_OUT(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .Sum(s8), .Carry(c8), .A(a8), .B(b8), .CI(ci8));
    full_adder #(.WIDTH(16), .REG_OUT(1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .Sum(s16), .Carry(c16), .A(a16), .B(b16), .CI(ci16));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {A,B,CI,Carry,Sum}, expected values computed by hand
    logic [4:0] tv [8] = '{5'b000_00, 5'b010_01, 5'b100_01, 5'b110_10,
                           5'b001_01, 5'b011_10, 5'b101_10, 5'b111_11};

    initial begin
        logic [4:0]  v;
        logic [16:0] exp16;
        bit          done;
        {a1, b1, ci1} = 3'b111;
        {a0, b0, ci0} = 3'b000;
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
        repeat (2) tick();
        check("reset_w1", {c1, s1}, 2'b00);
        check("reset_w8", {c8, s8}, 9'h000);
        check("reset_w16", {c16, s16}, 17'h00000);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            v = tv[i];
            {a1, b1, ci1} = v[4:2];
            tick();
            check($sformatf("tt_w1_%0d", i), {c1, s1}, v[1:0]);
        end

        {a1, b1, ci1} = 3'b111;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            done = (s1 === 1'b1) && (c1 === 1'b1);
        end
        check("pre_reset_out", {c1, s1}, 2'b11);
        {a1, b1, ci1} = 3'b000;
        #1;
        check("hold_between_edges", {c1, s1}, 2'b11);
        {a1, b1, ci1} = 3'b111;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", {c1, s1}, 2'b00);
        tick();
        check("reset_held_1", {c1, s1}, 2'b00);
        {a1, b1, ci1} = 3'b110;
        tick();
        check("reset_held_2", {c1, s1}, 2'b00);
        {a1, b1, ci1} = 3'b010;
        rst_n = 1'b1;
        #1;
        check("release_no_stale", {c1, s1}, 2'b00);
        tick();
        check("release_first_edge", {c1, s1}, 2'b01);

        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
        tick();
        check("w8_ff_00_1", {c8, s8}, 9'h100);
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        tick();
        check("w8_ff_ff_1", {c8, s8}, 9'h1FF);
        a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0;
        tick();
        check("w8_0f_01_0", {c8, s8}, 9'h010);
        a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
        tick();
        check("w8_zero", {c8, s8}, 9'h000);

        for (int i = 0; i < 8; i++) begin
            v = tv[i];
            {a0, b0, ci0} = v[4:2];
            #1;
            check($sformatf("tt_comb_%0d", i), {c0, s0}, v[1:0]);
        end

        for (int i = 0; i < 10000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            ci16 = 1'($urandom);
            exp16 = {1'b0, a16} + {1'b0, b16} + {16'd0, ci16};
            tick();
            check("rand_w16", {c16, s16}, exp16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
